// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the instruction decode stage.
// The immediate is carried at the widest XLEN and narrowed at the stage outputs.
package decode_pkg;

  localparam int IMM_W = 64;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef struct packed {
    fmt_e             fmt;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [IMM_W-1:0] imm;
    logic             is_w;
    logic             illegal;
  } decoded_t;

  function automatic logic is_w_opcode(input logic [6:0] opc);
    return (opc == OPC_OP_32) || (opc == OPC_OP_IMM_32);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational RV32/RV64 field extraction: format, register fields, sign-extended
// immediate and illegal-encoding detection. Illegal encodings report every field as 0.
module instr_field_decode
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [6:0] opc;
  logic [6:0] f7;
  fmt_e       fmt;
  logic       illegal;

  always_comb begin
    opc = instr[6:0];
    f7  = instr[31:25];
    case (opc)
      OPC_OP, OPC_OP_32:                                fmt = FMT_R;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32:    fmt = FMT_I;
      OPC_STORE:                                        fmt = FMT_S;
      OPC_BRANCH:                                       fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                               fmt = FMT_U;
      OPC_JAL:                                          fmt = FMT_J;
      default:                                          fmt = FMT_NONE;
    endcase

    illegal = (instr[1:0] != 2'b11) || (fmt == FMT_NONE) ||
              ((fmt == FMT_R) && (f7 != 7'b0000000) && (f7 != 7'b0100000) &&
               (f7 != 7'b0000001)) ||
              ((XLEN == 32) && is_w_opcode(opc));

    dec         = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = illegal;
    if (!illegal) begin
      dec.fmt    = fmt;
      dec.opcode = opc;
      dec.is_w   = is_w_opcode(opc);
      case (fmt)
        FMT_R: begin
          dec.funct3 = instr[14:12];
          dec.funct7 = f7;
          dec.rs1    = instr[19:15];
          dec.rs2    = instr[24:20];
          dec.rd     = instr[11:7];
        end
        FMT_I: begin
          dec.funct3 = instr[14:12];
          dec.rs1    = instr[19:15];
          dec.rd     = instr[11:7];
          dec.imm    = {{52{instr[31]}}, instr[31:20]};
        end
        FMT_S: begin
          dec.funct3 = instr[14:12];
          dec.rs1    = instr[19:15];
          dec.rs2    = instr[24:20];
          dec.imm    = {{52{instr[31]}}, instr[31:25], instr[11:7]};
        end
        FMT_B: begin
          dec.funct3 = instr[14:12];
          dec.rs1    = instr[19:15];
          dec.rs2    = instr[24:20];
          dec.imm    = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
        end
        FMT_U: begin
          dec.rd  = instr[11:7];
          dec.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
        end
        FMT_J: begin
          dec.rd  = instr[11:7];
          dec.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage with valid/ready handshakes on both sides and an optional
// skid slot so that in_ready does not depend combinationally on out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [2:0]      out_fmt,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_is_w,
  output logic            out_illegal
);

  decoded_t        in_dec;
  occ_e            state_q, state_d;
  decoded_t        main_dec_q, main_dec_d, skid_dec_q, skid_dec_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic            acc, take;

  instr_field_decode #(.XLEN(XLEN)) u_field_decode (
    .instr (in_instr),
    .dec   (in_dec)
  );

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_ready  = SKID_EN ? (state_q != OCC_TWO) : (!out_valid || out_ready);
  assign acc       = in_valid && in_ready;
  assign take      = out_valid && out_ready;

  always_comb begin
    state_d    = state_q;
    main_dec_d = main_dec_q;
    main_pc_d  = main_pc_q;
    skid_dec_d = skid_dec_q;
    skid_pc_d  = skid_pc_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (acc) begin
          state_d    = OCC_ONE;
          main_dec_d = in_dec;
          main_pc_d  = in_pc;
        end
      end
      OCC_ONE: begin
        if (acc && take) begin
          main_dec_d = in_dec;
          main_pc_d  = in_pc;
        end else if (acc && SKID_EN) begin
          // Consumer stalled: park the newcomer behind the head entry.
          state_d    = OCC_TWO;
          skid_dec_d = in_dec;
          skid_pc_d  = in_pc;
        end else if (take) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (take) begin
          state_d    = OCC_ONE;
          main_dec_d = skid_dec_q;
          main_pc_d  = skid_pc_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Redirect drops everything, including a same-cycle accept or take.
    if (flush) state_d = OCC_EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= OCC_EMPTY;
      main_dec_q <= '0;
      main_pc_q  <= '0;
      skid_dec_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      main_dec_q <= main_dec_d;
      main_pc_q  <= main_pc_d;
      skid_dec_q <= skid_dec_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign out_pc      = main_pc_q;
  assign out_fmt     = main_dec_q.fmt;
  assign out_opcode  = main_dec_q.opcode;
  assign out_funct3  = main_dec_q.funct3;
  assign out_funct7  = main_dec_q.funct7;
  assign out_rs1     = main_dec_q.rs1;
  assign out_rs2     = main_dec_q.rs2;
  assign out_rd      = main_dec_q.rd;
  assign out_imm     = main_dec_q.imm[XLEN-1:0];
  assign out_is_w    = main_dec_q.is_w;
  assign out_illegal = main_dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: table of hand-decoded instructions fed through a scoreboard,
// plus backpressure, flush, RV32 legality and async-reset sequences.
module tb_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        is_w;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [2:0]  out_fmt, out_funct3;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_is_w, out_illegal;

  logic        in_valid_32, in_ready_32, out_valid_32, out_ready_32;
  logic [31:0] in_instr_32, in_pc_32, out_pc_32, out_imm_32;
  logic [2:0]  out_fmt_32, out_funct3_32;
  logic [6:0]  out_opcode_32, out_funct7_32;
  logic [4:0]  out_rs1_32, out_rs2_32, out_rd_32;
  logic        out_is_w_32, out_illegal_32;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_fmt(out_fmt),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_is_w(out_is_w), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid_32), .in_ready(in_ready_32), .in_instr(in_instr_32),
    .in_pc(in_pc_32), .out_valid(out_valid_32), .out_ready(out_ready_32),
    .out_pc(out_pc_32), .out_fmt(out_fmt_32), .out_opcode(out_opcode_32),
    .out_funct3(out_funct3_32), .out_funct7(out_funct7_32), .out_rs1(out_rs1_32),
    .out_rs2(out_rs2_32), .out_rd(out_rd_32), .out_imm(out_imm_32),
    .out_is_w(out_is_w_32), .out_illegal(out_illegal_32)
  );

  vec_t vecs[16];
  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic [31:0] i, input logic [2:0] f,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d, input logic [63:0] imm,
                              input logic w, input logic ill);
    vec_t v;
    v.instr    = i;
    v.e.pc     = '0;
    v.e.fmt    = f;
    v.e.opcode = ill ? 7'd0 : i[6:0];
    v.e.funct3 = f3;
    v.e.funct7 = f7;
    v.e.rs1    = r1;
    v.e.rs2    = r2;
    v.e.rd     = d;
    v.e.imm    = imm;
    v.e.is_w   = w;
    v.e.illegal = ill;
    return v;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.pc = out_pc; o.fmt = out_fmt; o.opcode = out_opcode; o.funct3 = out_funct3;
    o.funct7 = out_funct7; o.rs1 = out_rs1; o.rs2 = out_rs2; o.rd = out_rd;
    o.imm = out_imm; o.is_w = out_is_w; o.illegal = out_illegal;
    return o;
  endfunction

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic offer(input int idx, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = vecs[idx].instr;
    in_pc    = pc;
    cur      = vecs[idx].e;
    cur.pc   = pc;
  endtask

  // One clock: score the take and the accept that the coming edge will perform.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out got pc=%0h required no output", out_pc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("dec_pc_%0h", e.pc), observed(), e);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    vecs[0]  = mk(32'h00500093, 3'd1, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'd5, 1'b0, 1'b0);
    vecs[1]  = mk(32'hFE000EE3, 3'd3, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    vecs[2]  = mk(32'h800000B7, 3'd4, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    vecs[3]  = mk(32'h002081B3, 3'd0, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 64'd0, 1'b0, 1'b0);
    vecs[4]  = mk(32'h40208133, 3'd0, 3'd0, 7'h20, 5'd1, 5'd2, 5'd2, 64'd0, 1'b0, 1'b0);
    vecs[5]  = mk(32'h023100BB, 3'd0, 3'd0, 7'h01, 5'd2, 5'd3, 5'd1, 64'd0, 1'b1, 1'b0);
    vecs[6]  = mk(32'hFE532C23, 3'd2, 3'd2, 7'h00, 5'd6, 5'd5, 5'd0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    vecs[7]  = mk(32'h001000EF, 3'd5, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 64'h800, 1'b0, 1'b0);
    vecs[8]  = mk(32'h80000067, 3'd1, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 1'b0);
    vecs[9]  = mk(32'h0011009B, 3'd1, 3'd0, 7'h00, 5'd2, 5'd0, 5'd1, 64'd1, 1'b1, 1'b0);
    vecs[10] = mk(32'h12345117, 3'd4, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 64'h1234_5000, 1'b0, 1'b0);
    vecs[11] = mk(32'h0040A183, 3'd1, 3'd2, 7'h00, 5'd1, 5'd0, 5'd3, 64'd4, 1'b0, 1'b0);
    vecs[12] = mk(32'h00000000, 3'd7, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b1);
    vecs[13] = mk(32'h0000007F, 3'd7, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b1);
    vecs[14] = mk(32'hFE0000B3, 3'd7, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b1);
    vecs[15] = mk(32'h00500091, 3'd7, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 1'b1);

    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    in_valid_32 = 1'b0; in_instr_32 = '0; in_pc_32 = '0; out_ready_32 = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_rd", out_rd, 5'd0);

    // Full-rate table sweep.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      offer(i, 64'h1000 + 64'(4 * i));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("table_latency_drain", sb.size(), 0);

    // Backpressure: two accepted, third refused until release.
    out_ready = 1'b0;
    offer(0, 64'h2000); step();
    offer(1, 64'h2004); step();
    offer(2, 64'h2008);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    chk("full_head_pc", out_pc, 64'h2000);
    step();
    chk("hold_head_pc", out_pc, 64'h2000);
    chk("hold_head_imm", out_imm, 64'd5);
    out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      done = in_ready;
      step();
    end
    chk("third_accepted", done, 1'b1);
    in_valid = 1'b0;
    repeat (4) step();
    chk("order_drain", sb.size(), 0);

    // Flush in TWO together with an offered instruction.
    out_ready = 1'b0;
    offer(3, 64'h3000); step();
    offer(4, 64'h3004); step();
    flush = 1'b1;
    offer(5, 64'h3BAD);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_out_valid", out_valid, 1'b0);
    chk("flush2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    offer(6, 64'h3010); step();
    in_valid = 1'b0; step();
    chk("flush2_drain", sb.size(), 0);

    // Flush in ONE overrides a same-cycle accept and take.
    offer(7, 64'h3100); step();
    flush = 1'b1;
    offer(8, 64'h3BAD2);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_out_valid", out_valid, 1'b0);
    step();
    chk("flush1_still_empty", out_valid, 1'b0);

    // RV32 instance: W opcode is illegal, LUI immediate is 32 bits wide.
    in_valid_32 = 1'b1; in_instr_32 = 32'h0000003B; in_pc_32 = 32'h40;
    @(posedge clk); #1;
    in_instr_32 = 32'h800000B7; in_pc_32 = 32'h44;
    chk("rv32_w_valid", out_valid_32, 1'b1);
    chk("rv32_w_illegal", out_illegal_32, 1'b1);
    chk("rv32_w_fmt", out_fmt_32, 3'd7);
    chk("rv32_w_fields", {out_opcode_32, out_rd_32, out_rs1_32, out_is_w_32}, 18'd0);
    @(posedge clk); #1;
    in_valid_32 = 1'b0;
    chk("rv32_lui_imm", out_imm_32, 32'h8000_0000);
    chk("rv32_lui_fmt_rd", {out_fmt_32, out_rd_32, out_illegal_32}, {3'd4, 5'd1, 1'b0});

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    offer(0, 64'h5000); step();
    offer(1, 64'h5004); step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_pc", out_pc, 64'd0);
    chk("arst_out_imm", out_imm, 64'd0);
    sb.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_stays_empty", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
